// File: rtl/hls4x2_5_pkg.sv
// Shared constants and types for the HLS4x2_5 dot-product accumulator slice.
package hls4x2_5_pkg;

  localparam int DATA_W       = 16;
  localparam int K_DEFAULT    = 4;
  localparam int NOUT_DEFAULT = 2;

  typedef logic signed [DATA_W-1:0] data_t;

endpackage

// File: rtl/hls4x2_5_add_ovf.sv
// Wrap-around adder with two's-complement signed overflow detect.
module hls4x2_5_add_ovf #(
  parameter int W = hls4x2_5_pkg::DATA_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s,
  output logic         ov
);

  // Overflow: operands agree in sign but the truncated sum does not.
  assign s  = a + b;
  assign ov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);

endmodule

// File: rtl/hls4x2_5_dot_acc.sv
// Sums each group of K signed products into one dot-product term with column
// index and sticky overflow; a single registered output slot with backpressure.
module hls4x2_5_dot_acc #(
  parameter int K      = hls4x2_5_pkg::K_DEFAULT,
  parameter int NOUT   = hls4x2_5_pkg::NOUT_DEFAULT,
  parameter int DATA_W = hls4x2_5_pkg::DATA_W,
  parameter int IDX_W  = (NOUT > 1) ? $clog2(NOUT) : 1
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic signed [DATA_W-1:0] din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic signed [DATA_W-1:0] dout,
  output logic                     dout_ovf,
  output logic [IDX_W-1:0]         dout_idx,
  output logic                     dout_valid,
  input  logic                     dout_ready
);
  import hls4x2_5_pkg::*;

  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

  logic [DATA_W-1:0] r_acc;
  logic              r_ovf_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_col;
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_ovf;
  logic [IDX_W-1:0]  r_dout_idx;
  logic              r_dout_valid;

  logic [DATA_W-1:0] w_sum;
  logic              w_ov;
  logic              w_last;
  logic              w_in_fire;
  logic              w_out_fire;

  hls4x2_5_add_ovf #(.W(DATA_W)) u_add (
    .a  (r_acc),
    .b  (din),
    .s  (w_sum),
    .ov (w_ov)
  );

  assign w_last     = (r_cnt == CNT_W'(K - 1));
  // Only the final term of a group needs the output slot, so only it can stall.
  assign din_ready  = !ap_rst && (!w_last || !r_dout_valid || dout_ready);
  assign w_in_fire  = din_valid && din_ready;
  assign w_out_fire = r_dout_valid && dout_ready;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_acc        <= '0;
      r_ovf_acc    <= 1'b0;
      r_cnt        <= '0;
      r_col        <= '0;
      r_dout       <= '0;
      r_dout_ovf   <= 1'b0;
      r_dout_idx   <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      if (w_in_fire) begin
        if (w_last) begin
          r_acc     <= '0;
          r_ovf_acc <= 1'b0;
          r_cnt     <= '0;
          r_col     <= (r_col == IDX_W'(NOUT - 1)) ? '0 : r_col + 1'b1;
        end else begin
          r_acc     <= w_sum;
          r_ovf_acc <= r_ovf_acc | w_ov;
          r_cnt     <= r_cnt + 1'b1;
        end
      end
      // A new result loading wins over a drain, so back-to-back results have no bubble.
      if (w_in_fire && w_last) begin
        r_dout       <= w_sum;
        r_dout_ovf   <= r_ovf_acc | w_ov;
        r_dout_idx   <= r_col;
        r_dout_valid <= 1'b1;
      end else if (w_out_fire) begin
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_ovf   = r_dout_ovf;
  assign dout_idx   = r_dout_idx;
  assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_hls4x2_5_dot_acc.sv
// Directed plus randomized bench for hls4x2_5_dot_acc against an integer-arithmetic group-sum model.
module tb_hls4x2_5_dot_acc;

  localparam int K    = 4;
  localparam int NOUT = 2;

  logic               ap_clk = 1'b0;
  logic               ap_rst;
  logic signed [15:0] din;
  logic               din_valid;
  logic               din_ready;
  logic signed [15:0] dout;
  logic               dout_ovf;
  logic [0:0]         dout_idx;
  logic               dout_valid;
  logic               dout_ready;

  hls4x2_5_dot_acc #(.K(K), .NOUT(NOUT), .DATA_W(16)) dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_ovf   (dout_ovf),
    .dout_idx   (dout_idx),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct packed {
    logic [15:0] d;
    logic        o;
    logic [0:0]  i;
  } res_t;

  res_t expQ[$];
  int   mAcc;
  bit   mOvf;
  int   mCnt;
  int   mCol;
  int   checks = 0;
  int   errors = 0;
  int   outCount = 0;
  res_t obsLast;
  logic acc;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, compare just before the edge, advance the model.
  task automatic cycle(input logic v, input logic signed [15:0] d, input logic r,
                       output logic accepted);
    logic expReady;
    logic inFire;
    logic outFire;
    int   t;
    logic [15:0] w;
    din_valid  = v;
    din        = d;
    dout_ready = r;
    #3;
    expReady = !((mCnt == K - 1) && (expQ.size() != 0) && !r);
    check("din_ready", {15'd0, din_ready}, {15'd0, expReady});
    check("dout_valid", {15'd0, dout_valid}, {15'd0, expQ.size() != 0});
    if (expQ.size() != 0) begin
      check("dout", dout, expQ[0].d);
      check("dout_ovf", {15'd0, dout_ovf}, {15'd0, expQ[0].o});
      check("dout_idx", {15'd0, dout_idx}, {15'd0, expQ[0].i});
    end
    outFire = (expQ.size() != 0) && r;
    inFire  = v && expReady;
    if (outFire) begin
      obsLast = '{d: dout, o: dout_ovf, i: dout_idx};
      void'(expQ.pop_front());
      outCount++;
    end
    if (inFire) begin
      t = mAcc + int'(d);
      if (t > 32767 || t < -32768) mOvf = 1'b1;
      w = t[15:0];
      if (mCnt == K - 1) begin
        expQ.push_back('{d: w, o: mOvf, i: 1'(mCol)});
        mAcc = 0;
        mOvf = 1'b0;
        mCnt = 0;
        mCol = (mCol + 1) % NOUT;
      end else begin
        mAcc = int'($signed(w));
        mCnt++;
      end
    end
    @(posedge ap_clk);
    #1;
    accepted = inFire;
  endtask

  task automatic sendProduct(input logic signed [15:0] d, input logic r);
    logic a;
    a = 1'b0;
    for (int n = 0; n < 20 && !a; n++) cycle(1'b1, d, r, a);
    check("send_timeout", {15'd0, a}, 16'd1);
  endtask

  task automatic idle(input int n, input logic r);
    logic a;
    for (int i = 0; i < n; i++) cycle(1'b0, 16'(($urandom)), r, a);
  endtask

  task automatic applyReset();
    ap_rst     = 1'b1;
    din_valid  = 1'b1;
    din        = 16'h1234;
    dout_ready = 1'b1;
    #3;
    check("din_ready_in_reset", {15'd0, din_ready}, 16'd0);
    @(posedge ap_clk);
    #1;
    ap_rst    = 1'b0;
    din_valid = 1'b0;
    expQ.delete();
    mAcc = 0;
    mOvf = 1'b0;
    mCnt = 0;
    mCol = 0;
    check("rst_dout", dout, 16'd0);
    check("rst_ovf", {15'd0, dout_ovf}, 16'd0);
    check("rst_idx", {15'd0, dout_idx}, 16'd0);
    check("rst_valid", {15'd0, dout_valid}, 16'd0);
  endtask

  initial begin
    int base;
    ap_rst = 1'b0;
    din_valid = 1'b0;
    din = '0;
    dout_ready = 1'b0;
    @(posedge ap_clk);
    #1;

    // Basic group 1..4
    applyReset();
    for (int i = 1; i <= 4; i++) sendProduct(16'(i), 1'b1);
    idle(1, 1'b1);
    check("basic_dout", obsLast.d, 16'd10);
    check("basic_idx", {15'd0, obsLast.i}, 16'd0);
    check("basic_ovf", {15'd0, obsLast.o}, 16'd0);

    // 16 back-to-back products
    applyReset();
    base = outCount;
    for (int i = 0; i < 16; i++) sendProduct(16'($urandom_range(0, 200)), 1'b1);
    idle(1, 1'b1);
    check("b2b_results", 16'(outCount - base), 16'd4);
    check("b2b_last_idx", {15'd0, obsLast.i}, 16'd1);

    // Overflow group followed by a clean group
    applyReset();
    sendProduct(16'h7FFF, 1'b1);
    sendProduct(16'h0001, 1'b1);
    sendProduct(16'h0000, 1'b1);
    sendProduct(16'h0000, 1'b1);
    idle(1, 1'b1);
    check("ovf_dout", obsLast.d, 16'h8000);
    check("ovf_flag", {15'd0, obsLast.o}, 16'd1);
    for (int i = 0; i < 4; i++) sendProduct(16'd1, 1'b1);
    idle(1, 1'b1);
    check("clean_dout", obsLast.d, 16'd4);
    check("clean_flag", {15'd0, obsLast.o}, 16'd0);

    // Backpressure on the final term
    for (int i = 0; i < 4; i++) sendProduct(16'($urandom_range(0, 100)), 1'b0);
    idle(1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 16'd7, 1'b0, acc);
      check("bp_nonfinal_acc", {15'd0, acc}, 16'd1);
    end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 16'd7, 1'b0, acc);
      check("bp_final_stall", {15'd0, acc}, 16'd0);
    end
    cycle(1'b1, 16'd7, 1'b1, acc);
    check("bp_release_acc", {15'd0, acc}, 16'd1);
    idle(1, 1'b1);
    check("bp_second", obsLast.d, 16'd28);

    // Reset mid-group
    applyReset();
    sendProduct(16'd5, 1'b1);
    sendProduct(16'd5, 1'b1);
    applyReset();
    for (int i = 0; i < 4; i++) sendProduct(16'd5, 1'b1);
    idle(1, 1'b1);
    check("midrst_dout", obsLast.d, 16'd20);
    check("midrst_idx", {15'd0, obsLast.i}, 16'd0);

    // Negative products with valid gaps
    for (int i = 1; i <= 4; i++) begin
      sendProduct(16'(-i), 1'b1);
      idle(i, 1'b1);
    end
    check("neg_dout", obsLast.d, 16'hFFF6);
    check("neg_ovf", {15'd0, obsLast.o}, 16'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 3) != 0), 16'($urandom), ($urandom_range(0, 2) != 0), acc);
    idle(3, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hls4x2_5_dot_acc.md
# hls4x2_5_dot_acc

Downstream consumer of the HLS4x2_5 16x16 signed multiplier. Accepts a stream of 16-bit signed products, one per cycle, and sums each group of K consecutive products into one dot-product term. Results are emitted with a column index and a sticky overflow flag. Sits between the multiplier and the result store of the 4x2 matrix datapath. Arithmetic wraps modulo 2^16, matching the multiplier's truncated output.

## Interface
Parameters:
- K, 4, products per dot-product term; K ≥ 2
- NOUT, 2, result columns per output row; `dout_idx` cycles 0..NOUT-1
- DATA_W, 16, product and result width

Ports:
- ap_clk  in  1  clock, rising edge
- ap_rst  in  1  reset, synchronous, active-high
- din  in  DATA_W  signed product from the multiplier
- din_valid  in  1  `din` valid
- din_ready  out  1  block accepts `din` this cycle
- dout  out  DATA_W  signed dot-product result, wrapped mod 2^DATA_W
- dout_ovf  out  1  signed overflow occurred in any partial sum of this result
- dout_idx  out  max(1,$clog2(NOUT))  column index of `dout`
- dout_valid  out  1  result valid
- dout_ready  in  1  downstream accepts result

## Operation
- Registers:
  - `acc` (DATA_W)
  - `ovf_acc` (1)
  - `cnt` (0..K-1)
  - output register {`dout`, `dout_ovf`, `dout_idx`, `dout_valid`}
  - `col` (0..NOUT-1)
- Transfer in: `din_valid && din_ready`. Transfer out: `dout_valid && dout_ready`.
- Per-transfer sum: `s = acc + din`, truncated to DATA_W. Overflow detect: `ov = (acc[MSB]==din[MSB]) && (s[MSB]!=acc[MSB])`.
- Transfer in with `cnt < K-1`:
  - `acc <= s`, `ovf_acc <= ovf_acc | ov`, `cnt++`.
- Transfer in with `cnt == K-1`:
  - `dout <= s`, `dout_ovf <= ovf_acc | ov`, `dout_idx <= col`, `dout_valid <= 1`.
  - `acc <= 0`, `ovf_acc <= 0`, `cnt <= 0`.
  - `col <= (col == NOUT-1) ? 0 : col+1`.
- Transfer out without a simultaneous result load: `dout_valid <= 0`. `dout`, `dout_ovf` and `dout_idx` hold their last value.
- `din_ready = !ap_rst && ((cnt != K-1) || !dout_valid || dout_ready)`.
  - Non-final terms are never stalled by the output.
  - Only the final term waits for a free output slot.
- Simultaneous transfer out and final-term transfer in: the new result loads and `dout_valid` stays 1. No bubble; no loss.
- `din` is ignored when `din_valid` = 0. `acc` and `cnt` hold.
- Two implicit states, selected by `cnt` and `dout_valid`, with no separate FSM register:
  - ACCUM: `cnt < K-1`.
  - LAST: `cnt == K-1`, stalls when `dout_valid && !dout_ready`.

## Timing
- Reset values (ap_rst = 1 at a rising edge): `acc` = 0, `ovf_acc` = 0, `cnt` = 0, `col` = 0, `dout` = 0, `dout_ovf` = 0, `dout_idx` = 0, `dout_valid` = 0.
- `din_ready` is 0 while `ap_rst` is high.
- Reset mid-group discards the partial sum and any pending result.
- Latency: final-term accept at edge N gives `dout_valid` = 1 after edge N.
- Throughput: one product per cycle sustained while `dout_ready` = 1. One result every K cycles.
- Backpressure: `dout` and `dout_idx` stay stable while `dout_valid && !dout_ready`.
- All outputs except `din_ready` are registered. `din_ready` is combinational from `cnt`, `dout_valid`, `dout_ready` and `ap_rst`.

## Structure
- Package `hls4x2_5_pkg`: constants DATA_W = 16, K_DEFAULT = 4, NOUT_DEFAULT = 2, and the typedef `data_t` = logic signed [DATA_W-1:0].
- Sub-module `hls4x2_5_add_ovf`: combinational wrap-around add with signed overflow detect. Inputs a, b; outputs s, ov.
- Top module: counters, accumulator and output register.

## Test plan
- Reset, then stream 1, 2, 3, 4 with `dout_ready` = 1 -> `dout` = 10, `dout_idx` = 0, `dout_ovf` = 0, `dout_valid` one cycle after the 4th accept.
- 16 back-to-back products with `dout_ready` = 1 -> 4 results, idx sequence 0, 1, 0, 1, `din_ready` never low.
- Products 0x7FFF, 0x0001, 0x0000, 0x0000 -> `dout` = 0x8000 (-32768), `dout_ovf` = 1. The next group 1, 1, 1, 1 -> `dout` = 4, `dout_ovf` = 0.
- `dout_ready` = 0 while a second group streams -> first 3 terms accepted, `din_ready` = 0 on the 4th, `dout` holds the first result. Raise `dout_ready` -> the 4th term is accepted in the same cycle, and the second result appears next cycle with no gap.
- Assert `ap_rst` after 2 of 4 terms, then stream 5, 5, 5, 5 -> `dout` = 20, `dout_idx` = 0.
- Inputs -1, -2, -3, -4 with `din_valid` gaps between them -> `dout` = 0xFFF6 (-10), `dout_ovf` = 0.
